// File: rtl/day3_battery_streamer.sv
// Battery-bank loader and streamer. ASCII digit lines are stored per bank.
// The banks are then replayed one digit column per cycle across NUM_UNITS parallel lanes.
module day3_battery_streamer #(
    parameter int NUM_UNITS    = 200,
    parameter int MAX_PACK     = 100,
    parameter int DRAIN_CYCLES = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     init,
    output logic [8*NUM_UNITS-1:0]   battery_pack_size,
    output logic                     en,
    output logic [4*NUM_UNITS-1:0]   next_battery,
    output logic                     done,
    output logic                     error
);

    localparam int K_W = $clog2(MAX_PACK + 1);
    localparam int A_W = (MAX_PACK > 1) ? $clog2(MAX_PACK) : 1;
    localparam int B_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int D_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    localparam logic [2:0] S_LOAD   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [B_W-1:0]         bank_q, bank_d;
    logic [K_W-1:0]         cnt_q, cnt_d;
    logic [7:0]             l_q, l_d;
    logic [K_W-1:0]         k_q, k_d;
    logic [D_W-1:0]         drain_q, drain_d;
    logic                   error_q, error_d;
    logic                   in_ready_q;
    logic                   init_q;
    logic                   en_q;
    logic                   done_q;
    logic [4*NUM_UNITS-1:0] lane_q, lane_d;
    logic [7:0]             size_q [NUM_UNITS];
    logic [3:0]             mem_q  [NUM_UNITS][MAX_PACK];

    logic accept;
    logic is_digit;
    logic is_cr;
    logic is_lf;
    logic bank_full;
    logic store_digit;
    logic close_bank;
    logic bad_byte;

    // in_ready_q is only high in LOAD, so it doubles as the state qualifier.
    assign accept      = in_valid && in_ready_q;
    assign is_digit    = (in_data >= 8'h30) && (in_data <= 8'h39);
    assign is_cr       = (in_data == 8'h0D);
    assign is_lf       = (in_data == 8'h0A);
    assign bank_full   = (cnt_q == K_W'(MAX_PACK));
    assign store_digit = accept && is_digit && !bank_full;
    assign close_bank  = accept && is_lf && (cnt_q != '0);
    assign bad_byte    = accept && (is_digit ? bank_full : !(is_cr || is_lf));

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path infers a latch.
        state_d = state_q;
        bank_d  = bank_q;
        cnt_d   = cnt_q;
        l_d     = l_q;
        k_d     = k_q;
        drain_d = drain_q;
        error_d = error_q || bad_byte;
        case (state_q)
            S_LOAD: begin
                if (close_bank) begin
                    l_d    = (8'(cnt_q) > l_q) ? 8'(cnt_q) : l_q;
                    cnt_d  = '0;
                    bank_d = bank_q + B_W'(1);
                    if (bank_q == B_W'(NUM_UNITS - 1)) begin
                        state_d = S_INIT;
                    end
                end else if (store_digit) begin
                    cnt_d = cnt_q + K_W'(1);
                end
            end
            S_INIT: begin
                state_d = S_STREAM;
                k_d     = '0;
            end
            S_STREAM: begin
                if (k_q == K_W'(l_q - 8'd1)) begin
                    state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                    drain_d = '0;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == D_W'(DRAIN_CYCLES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + D_W'(1);
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_LOAD;
        endcase
    end

    // Lanes are computed from the next state/column so en and data register together.
    always_comb begin
        lane_d = '0;
        if (state_d == S_STREAM) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (8'(k_d) < size_q[i]) begin
                    lane_d[4*i +: 4] = mem_q[i][k_d[A_W-1:0]];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q    <= S_LOAD;
            bank_q     <= '0;
            cnt_q      <= '0;
            l_q        <= '0;
            k_q        <= '0;
            drain_q    <= '0;
            error_q    <= 1'b0;
            in_ready_q <= 1'b0;
            init_q     <= 1'b0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            lane_q     <= '0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                size_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            cnt_q      <= cnt_d;
            l_q        <= l_d;
            k_q        <= k_d;
            drain_q    <= drain_d;
            error_q    <= error_d;
            in_ready_q <= (state_d == S_LOAD);
            init_q     <= (state_d == S_INIT);
            en_q       <= (state_d == S_STREAM);
            done_q     <= (state_d == S_DONE);
            lane_q     <= lane_d;
            if (close_bank) begin
                size_q[bank_q] <= 8'(cnt_q);
            end
        end
    end

    // NOTE: digit storage has no reset; bank sizes gate every read, so stale contents never reach a lane.
    always_ff @(posedge clock) begin
        if (store_digit) begin
            mem_q[bank_q][cnt_q[A_W-1:0]] <= in_data[3:0];
        end
    end

    always_comb begin
        battery_pack_size = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            battery_pack_size[8*i +: 8] = size_q[i];
        end
    end

    assign in_ready     = in_ready_q;
    assign init         = init_q;
    assign en           = en_q;
    assign next_battery = lane_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_day3_battery_streamer.sv
// Directed bench for day3_battery_streamer: a reference parser pushes expected lane beats
// to a scoreboard that a negedge monitor pops whenever en is high.
module tb_day3_battery_streamer;

    localparam int NU = 2;
    localparam int MP = 4;
    localparam int DC = 10;

    logic            clock    = 1'b0;
    logic            reset    = 1'b0;
    logic            in_valid = 1'b0;
    logic [7:0]      in_data  = 8'h00;
    logic            in_ready;
    logic            init;
    logic [8*NU-1:0] battery_pack_size;
    logic            en;
    logic [4*NU-1:0] next_battery;
    logic            done;
    logic            error;

    day3_battery_streamer #(
        .NUM_UNITS   (NU),
        .MAX_PACK    (MP),
        .DRAIN_CYCLES(DC)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .init             (init),
        .battery_pack_size(battery_pack_size),
        .en               (en),
        .next_battery     (next_battery),
        .done             (done),
        .error            (error)
    );

    always #5 clock = ~clock;

    int              n_vec = 0;
    int              n_mis = 0;
    logic [4*NU-1:0] sb [$];
    logic [8*NU-1:0] exp_sizes;
    logic            exp_err;
    int              exp_l;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference parser: derives bank sizes, error, L and the expected beats.
    task automatic model_and_push(input string s);
        int         cnt  = 0;
        int         bank = 0;
        logic [7:0] c;
        logic [3:0] dig [NU][MP];
        int         sz  [NU];
        for (int u = 0; u < NU; u++) begin
            sz[u] = 0;
            for (int p = 0; p < MP; p++) dig[u][p] = 4'h0;
        end
        exp_err = 1'b0;
        exp_l   = 0;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (bank >= NU) break;
            if (c >= 8'h30 && c <= 8'h39) begin
                if (cnt == MP) exp_err = 1'b1;
                else begin
                    dig[bank][cnt] = 4'(c - 8'h30);
                    cnt++;
                end
            end else if (c == 8'h0A) begin
                if (cnt > 0) begin
                    sz[bank] = cnt;
                    if (cnt > exp_l) exp_l = cnt;
                    bank++;
                    cnt = 0;
                end
            end else if (c != 8'h0D) begin
                exp_err = 1'b1;
            end
        end
        for (int u = 0; u < NU; u++) exp_sizes[8*u +: 8] = 8'(sz[u]);
        for (int k = 0; k < exp_l; k++) begin
            logic [4*NU-1:0] beat = '0;
            for (int u = 0; u < NU; u++) begin
                if (k < sz[u]) beat[4*u +: 4] = dig[u][k];
            end
            sb.push_back(beat);
        end
    endtask

    task automatic send(input string s, input bit hold);
        model_and_push(s);
        for (int i = 0; i < s.len(); i++) begin
            int g   = 0;
            bit acc = 1'b0;
            in_valid = 1'b1;
            in_data  = s[i];
            while (!acc && g < 100) begin
                @(negedge clock);
                if (in_ready === 1'b1) begin
                    @(posedge clock);
                    #1;
                    acc = 1'b1;
                end
                g++;
            end
            if (!acc) check("in_ready_timeout", 64'(acc), 64'(1));
        end
        if (hold) in_data = 8'h35;
        else      in_valid = 1'b0;
    endtask

    task automatic wait_init();
        int g = 0;
        @(negedge clock);
        while (init !== 1'b1 && g < 50) begin
            @(negedge clock);
            g++;
        end
        check("init_seen", 64'(init), 64'(1));
    endtask

    task automatic run_check();
        int ne      = 0;
        int nz      = 0;
        bit zero_ok = 1'b1;
        wait_init();
        check("sizes_at_init", 64'(battery_pack_size), 64'(exp_sizes));
        check("in_ready_init", 64'(in_ready), 64'(0));
        check("error_flag", 64'(error), 64'(exp_err));
        @(negedge clock);
        check("init_one_cycle", 64'(init), 64'(0));
        while (en === 1'b1 && ne < 300) begin
            ne++;
            if (in_ready !== 1'b0) zero_ok = 1'b0;
            @(negedge clock);
        end
        check("en_cycles", 64'(ne), 64'(exp_l));
        while (done !== 1'b1 && nz < 300) begin
            if (next_battery !== '0 || en !== 1'b0 || in_ready !== 1'b0) zero_ok = 1'b0;
            nz++;
            @(negedge clock);
        end
        check("drain_cycles", 64'(nz), 64'(DC));
        check("drain_quiet", 64'(zero_ok), 64'(1));
        check("done_flag", 64'(done), 64'(1));
        check("in_ready_done", 64'(in_ready), 64'(0));
        check("en_done", 64'(en), 64'(0));
        check("sb_drained", 64'(sb.size()), 64'(0));
        check("sizes_hold", 64'(battery_pack_size), 64'(exp_sizes));
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
    endtask

    always @(negedge clock) begin
        if (reset === 1'b0 && en === 1'b1) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) check("lane_digits", 64'(next_battery), 64'(sb.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, then first edge after release.
        #1 reset = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_init", 64'(init), 64'(0));
        check("rst_en", 64'(en), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        check("rst_lanes", 64'(next_battery), 64'(0));
        check("rst_sizes", 64'(battery_pack_size), 64'(0));
        @(negedge clock);
        reset = 1'b0;
        #1 check("in_ready_before_edge", 64'(in_ready), 64'(0));
        @(posedge clock);
        #1 check("in_ready_after_release", 64'(in_ready), 64'(1));

        // Basic stream; sizes also pinned to literal values.
        send("987\n811\n", 1'b0);
        check("basic_model_sizes", 64'(exp_sizes), 64'(16'h0303));
        run_check();

        // CRLF and an empty line.
        do_reset();
        send("12\r\n\n34\r\n", 1'b0);
        run_check();

        // Unequal lengths with a held byte after the last line.
        do_reset();
        send("12\n3456\n", 1'b1);
        run_check();
        check("held_byte_not_taken", 64'(error), 64'(0));
        in_valid = 1'b0;

        // Overflow and an illegal character.
        do_reset();
        send("12345\n1x2\n", 1'b0);
        check("ovf_model_sizes", 64'(exp_sizes), 64'(16'h0204));
        run_check();

        // Reset after the second en cycle, then a full reload.
        do_reset();
        send("987\n811\n", 1'b0);
        wait_init();
        @(negedge clock);
        @(negedge clock);
        check("en_before_abort", 64'(en), 64'(1));
        #2 reset = 1'b1;
        #1;
        check("abort_en", 64'(en), 64'(0));
        check("abort_lanes", 64'(next_battery), 64'(0));
        check("abort_init", 64'(init), 64'(0));
        check("abort_in_ready", 64'(in_ready), 64'(0));
        check("abort_sizes", 64'(battery_pack_size), 64'(0));
        sb.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1 check("in_ready_after_abort", 64'(in_ready), 64'(1));
        check("no_en_after_abort", 64'(en), 64'(0));
        send("987\n811\n", 1'b0);
        run_check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
